// File: rtl/ps2_keyboard_rx_if.sv
// Event stream from the PS/2 receiver FIFO to its consumer.
// The master drives valid and data. The slave drives ready, and a word moves when both valid and ready are high.
interface ps2_keyboard_rx_if;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: oversampled frame decode, E0/F0 folding into 10-bit events, event FIFO; PS2_REPEAT_FILTER_EN drops typematic repeats.
// Stop-bit fall in cycle E gives a push in E+1 and out_valid in E+2; when full, an event is dropped unless the same cycle pops.
module ps2_keyboard_rx #(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    ps2_keyboard_rx_if.master             out_if,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   clk_last_q;
    logic                   clk_s;
    logic                   dat_s;
    logic                   fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_last_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_last_q <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign clk_s = clk_sync_q[SYNC_STAGES-1];
    assign dat_s = dat_sync_q[SYNC_STAGES-1];
    assign fall  = clk_last_q & ~clk_s;

    logic [1:0]    state_q,    state_d;
    logic [2:0]    bit_cnt_q,  bit_cnt_d;
    logic [7:0]    shift_q,    shift_d;
    logic          parity_q,   parity_d;
    logic [TW-1:0] to_cnt_q,   to_cnt_d;
    logic [7:0]    byte_q,     byte_d;
    logic          byte_vld_q, byte_vld_d;
    logic          err_q,      err_d;
    logic          timeout;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        byte_d     = byte_q;
        byte_vld_d = 1'b0;
        err_d      = 1'b0;
        timeout    = (state_q != ST_IDLE) && !fall && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

        if (state_q == ST_IDLE || fall) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        // An edge in the same cycle as the limit counts as progress, so the edge wins.
        if (timeout) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end else if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!dat_s) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {dat_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_d = dat_s;
                    state_d  = ST_STOP;
                end
                default: begin
                    state_d = ST_IDLE;
                    if ((^{shift_q, parity_q}) && dat_s) begin
                        byte_vld_d = 1'b1;
                        byte_d     = shift_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            to_cnt_q   <= '0;
            byte_q     <= '0;
            byte_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            to_cnt_q   <= to_cnt_d;
            byte_q     <= byte_d;
            byte_vld_q <= byte_vld_d;
            err_q      <= err_d;
        end
    end

    assign frame_err = err_q;

    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic       evt_vld;
    logic [9:0] evt_dat;
    logic       push_vld;

    assign evt_dat = {brk_q, ext_q, byte_q};

    always_comb begin
        ext_d   = ext_q;
        brk_d   = brk_q;
        evt_vld = 1'b0;
        if (byte_vld_q) begin
            if (byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                evt_vld = 1'b1;
                ext_d   = 1'b0;
                brk_d   = 1'b0;
            end
        end
        if (err_d) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else begin
            ext_q <= ext_d;
            brk_q <= brk_d;
        end
    end

`ifdef PS2_REPEAT_FILTER_EN
    logic [8:0] last_make_q, last_make_d;
    logic       last_vld_q,  last_vld_d;
    logic       last_match;

    assign last_match = last_vld_q && (last_make_q == {ext_q, byte_q});

    always_comb begin
        last_make_d = last_make_q;
        last_vld_d  = last_vld_q;
        push_vld    = 1'b0;
        if (evt_vld) begin
            if (!brk_q) begin
                if (!last_match) begin
                    push_vld    = 1'b1;
                    last_make_d = {ext_q, byte_q};
                    last_vld_d  = 1'b1;
                end
            end else begin
                push_vld = 1'b1;
                if (last_match) begin
                    last_vld_d = 1'b0;
                end
            end
        end
        if (err_d) begin
            last_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_make_q <= '0;
            last_vld_q  <= 1'b0;
        end else begin
            last_make_q <= last_make_d;
            last_vld_q  <= last_vld_d;
        end
    end
`else
    assign push_vld = evt_vld;
`endif

    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q,  count_d;
    logic          ovf_q,    ovf_d;
    logic          full;
    logic          pop;
    logic          push_ok;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign pop     = out_if.out_valid && out_if.out_ready;
    assign push_ok = push_vld && (!full || pop);
    assign ovf_d   = push_vld && full && !pop;

    always_comb begin
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= evt_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Gating with valid keeps the storage array reset-free while the port still reads zero when empty.
    assign out_if.out_valid = (count_q != '0);
    assign out_if.out_data  = out_if.out_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_count       = count_q;
    assign overflow         = ovf_q;
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: a vector table plus hand-written sequences, with events checked through a queue.
module tb_ps2_keyboard_rx;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int TMO   = 200;
    localparam int H     = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [2:0] fifo_count;
    logic       frame_err;
    logic       overflow;

    ps2_keyboard_rx_if bus ();

    ps2_keyboard_rx #(
        .FIFO_DEPTH    (DEPTH),
        .SYNC_STAGES   (SYNC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .out_if    (bus),
        .fifo_count(fifo_count),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int err_cnt = 0;
    int ovf_cnt = 0;
    logic [9:0] exp_q [$];

    typedef struct {
        logic [23:0] bytes;
        int          n;
        bit          bad;
        bit          has_evt;
        logic [9:0]  exp;
    } vec_t;

    vec_t tbl [9];

    // Inputs change 2 time units after a rising edge. A handshake seen at the falling edge therefore completes at the next rising edge.
    always @(negedge clk) begin
        logic [9:0] e;
        if (frame_err) err_cnt++;
        if (overflow) ovf_cnt++;
        if (bus.out_valid && bus.out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL event: got %03h, expected no event", bus.out_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.out_data !== e) begin
                    n_fail++;
                    $display("FAIL event: got %03h, expected %03h", bus.out_data, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        tick(H);
        ps2_clk = 1'b0;
        tick(H);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~(^b) ^ bad);
        ps2_bit(1'b1);
    endtask

    initial begin
        int e0;
        int o0;
        logic [7:0] mk [5];
        logic [7:0] v;

        tbl[0] = '{24'h00001C, 1, 1'b0, 1'b1, 10'h01C};
        tbl[1] = '{24'h001CF0, 2, 1'b0, 1'b1, 10'h21C};
        tbl[2] = '{24'h0074E0, 2, 1'b0, 1'b1, 10'h174};
        tbl[3] = '{24'h74F0E0, 3, 1'b0, 1'b1, 10'h374};
        tbl[4] = '{24'h74E0F0, 3, 1'b0, 1'b1, 10'h374};
        tbl[5] = '{24'h00001C, 1, 1'b1, 1'b0, 10'h000};
        tbl[6] = '{24'h00001B, 1, 1'b0, 1'b1, 10'h01B};
        tbl[7] = '{24'h1CF0E0, 3, 1'b1, 1'b0, 10'h000};
        tbl[8] = '{24'h00002B, 1, 1'b0, 1'b1, 10'h02B};
        mk[0] = 8'h15; mk[1] = 8'h1D; mk[2] = 8'h24; mk[3] = 8'h2D; mk[4] = 8'h2C;

        bus.out_ready = 1'b0;
        tick(3);
        check("rst out_valid", bus.out_valid, 0);
        check("rst out_data", bus.out_data, 0);
        check("rst fifo_count", fifo_count, 0);
        check("rst frame_err", frame_err, 0);
        check("rst overflow", overflow, 0);
        rst_n = 1'b1;
        tick(5);

        // Single make event held in the FIFO, then popped.
        exp_q.push_back(10'h01C);
        send_byte(8'h1C, 1'b0);
        tick(20);
        check("single out_valid", bus.out_valid, 1);
        check("single out_data", bus.out_data, 10'h01C);
        check("single fifo_count", fifo_count, 1);
        bus.out_ready = 1'b1;
        tick(2);
        check("single popped count", fifo_count, 0);
        check("single drained", exp_q.size(), 0);

        for (int i = 0; i < 9; i++) begin
            e0 = err_cnt;
            if (tbl[i].has_evt) exp_q.push_back(tbl[i].exp);
            for (int j = 0; j < tbl[i].n; j++) begin
                v = tbl[i].bytes[j*8 +: 8];
                send_byte(v, tbl[i].bad && (j == tbl[i].n - 1));
            end
            tick(20);
            check($sformatf("vec%0d frame_err", i), err_cnt - e0, tbl[i].bad ? 1 : 0);
            check($sformatf("vec%0d drained", i), exp_q.size(), 0);
            check($sformatf("vec%0d count", i), fifo_count, 0);
        end

        // Overflow, followed by a push and a pop in the same cycle while full.
        bus.out_ready = 1'b0;
        o0 = ovf_cnt;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) exp_q.push_back({2'b00, mk[k]});
            send_byte(mk[k], 1'b0);
        end
        tick(20);
        check("ovf count", fifo_count, 4);
        check("ovf pulses", ovf_cnt - o0, 1);
        check("ovf head", bus.out_data, 10'h015);
        exp_q.push_back(10'h01C);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(i inside {2, 3, 4});
        ps2_bit(1'b0);
        ps2_data = 1'b1;
        tick(H);
        ps2_clk = 1'b0;
        tick(SYNC + 1);
        bus.out_ready = 1'b1;
        tick(1);
        bus.out_ready = 1'b0;
        tick(H);
        ps2_clk = 1'b1;
        tick(5);
        check("full push+pop count", fifo_count, 4);
        check("full push+pop no ovf", ovf_cnt - o0, 1);
        bus.out_ready = 1'b1;
        tick(20);
        check("ovf drained", exp_q.size(), 0);
        check("ovf drained count", fifo_count, 0);

        // A timeout after a prefix and 4 data bits clears the prefix.
        e0 = err_cnt;
        send_byte(8'hE0, 1'b0);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        tick(TMO + 50);
        check("timeout frame_err", err_cnt - e0, 1);
        exp_q.push_back(10'h023);
        send_byte(8'h23, 1'b0);
        tick(20);
        check("timeout next event", exp_q.size(), 0);
        check("timeout single err", err_cnt - e0, 1);

        // Typematic repeats.
        exp_q.push_back(10'h01C);
`ifndef PS2_REPEAT_FILTER_EN
        exp_q.push_back(10'h01C);
        exp_q.push_back(10'h01C);
`endif
        exp_q.push_back(10'h21C);
        for (int i = 0; i < 3; i++) send_byte(8'h1C, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        tick(20);
        check("repeat drained", exp_q.size(), 0);

        // Reset mid-frame with the FIFO holding an entry.
        bus.out_ready = 1'b0;
        send_byte(8'h2B, 1'b0);
        tick(20);
        check("pre-reset count", fifo_count, 1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b0;
        tick(H);
        ps2_clk = 1'b0;
        e0 = err_cnt;
        rst_n = 1'b0;
        tick(2);
        check("midrst out_valid", bus.out_valid, 0);
        check("midrst count", fifo_count, 0);
        check("midrst out_data", bus.out_data, 0);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(TMO + 20);
        check("midrst no frame_err", err_cnt - e0, 0);
        bus.out_ready = 1'b1;
        exp_q.push_back(10'h01B);
        send_byte(8'h1B, 1'b0);
        tick(20);
        check("post-reset event", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
